// File: rtl/eth_lsu_axil_bridge_pkg.sv
// Shared types and constants for the core-LSU to AXI4-Lite bridge in front of the Ethernet MAC.
package eth_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0]  AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR   = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR   = 2'b11;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  // EXOKAY counts as success; only SLVERR/DECERR are reported as errors.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/eth_lsu_axil_bridge_if.sv
// AXI4-Lite bus between the bridge (master) and the MAC s_axi_* port (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid, once raised, holds its payload stable until that edge (timeout/reset excepted).
interface eth_lsu_axil_bridge_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/eth_lsu_axil_bridge.sv
// Turns single-beat core loads/stores into one-at-a-time AXI4-Lite accesses to the Ethernet MAC,
// with a bounded timeout so a dead slave never stalls the core.
module eth_lsu_axil_bridge
  import eth_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_gnt,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timeout_flag,
  output logic        m_axi_aresetn,
  eth_lsu_axil_bridge_if.master m_axi,
  output state_t      dbg_state
);

  localparam int             CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic          aw_pend;
  logic          w_pend;
  logic          tmo_hit;

  assign req_gnt      = req_valid && (state == ST_IDLE);
  assign dbg_state    = state;
  assign m_axi.awprot = 3'b000;

  always_comb begin
    aw_pend = m_axi.awvalid && !m_axi.awready;
    w_pend  = m_axi.wvalid  && !m_axi.wready;
    tmo_hit = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge msoc_clk) begin
    if (!rstn) m_axi_aresetn <= 1'b0;
    else       m_axi_aresetn <= 1'b1;
  end

  always_ff @(posedge msoc_clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      tmo_cnt       <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.bready  <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state != ST_IDLE) tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_hit) begin
        // Abandon: drop every handshake so a late B/R is never accepted.
        state         <= ST_IDLE;
        m_axi.awvalid <= 1'b0;
        m_axi.wvalid  <= 1'b0;
        m_axi.bready  <= 1'b0;
        m_axi.arvalid <= 1'b0;
        m_axi.rready  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_err       <= 1'b1;
        rsp_rdata     <= ERR_RDATA;
        timeout_flag  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_gnt) begin
              tmo_cnt <= '0;
              if (req_we) begin
                m_axi.awaddr  <= word_align(req_addr);
                m_axi.wdata   <= req_wdata;
                m_axi.wstrb   <= req_be;
                m_axi.awvalid <= 1'b1;
                m_axi.wvalid  <= 1'b1;
                state         <= ST_WR_REQ;
              end else begin
                m_axi.araddr  <= word_align(req_addr);
                m_axi.arvalid <= 1'b1;
                state         <= ST_RD_REQ;
              end
            end
          end
          ST_WR_REQ: begin
            // AW and W complete independently, in either order or together.
            if (!aw_pend) m_axi.awvalid <= 1'b0;
            if (!w_pend)  m_axi.wvalid  <= 1'b0;
            if (!aw_pend && !w_pend) begin
              m_axi.bready <= 1'b1;
              state        <= ST_WR_RESP;
            end
          end
          ST_WR_RESP: begin
            if (m_axi.bvalid) begin
              m_axi.bready <= 1'b0;
              state        <= ST_IDLE;
              rsp_valid    <= 1'b1;
              rsp_err      <= resp_is_err(m_axi.bresp);
              rsp_rdata    <= '0;
            end
          end
          ST_RD_REQ: begin
            if (m_axi.arready) begin
              m_axi.arvalid <= 1'b0;
              m_axi.rready  <= 1'b1;
              state         <= ST_RD_RESP;
            end
          end
          ST_RD_RESP: begin
            if (m_axi.rvalid) begin
              m_axi.rready <= 1'b0;
              state        <= ST_IDLE;
              rsp_valid    <= 1'b1;
              rsp_err      <= resp_is_err(m_axi.rresp);
              rsp_rdata    <= resp_is_err(m_axi.rresp) ? ERR_RDATA : m_axi.rdata;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_lsu_axil_bridge.sv
// Bench for eth_lsu_axil_bridge: table of accesses against a scripted AXI slave, plus reset corner cases.
module tb_eth_lsu_axil_bridge;
  import eth_bridge_pkg::*;

  localparam int TO = 16;

  logic        msoc_clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_gnt;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        timeout_flag;
  logic        m_axi_aresetn;
  state_t      dbg_state;

  eth_lsu_axil_bridge_if ax();

  eth_lsu_axil_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .msoc_clk      (msoc_clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .req_gnt       (req_gnt),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .timeout_flag  (timeout_flag),
    .m_axi_aresetn (m_axi_aresetn),
    .m_axi         (ax),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 msoc_clk = ~msoc_clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          a_dly;
    int          w_dly;
    int          r_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        to;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  logic        seen_to = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every rsp_valid pulse must match the oldest expected response
  always @(negedge msoc_clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 want no response at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_err_rdata", 64'({rsp_err, rsp_rdata}), 64'(mon_exp));
      end
    end
  end

  task automatic slave_idle();
    ax.awready = 1'b0;
    ax.wready  = 1'b0;
    ax.bvalid  = 1'b0;
    ax.bresp   = 2'b00;
    ax.arready = 1'b0;
    ax.rvalid  = 1'b0;
    ax.rdata   = 32'h0;
    ax.rresp   = 2'b00;
  endtask

  // Drives one request at the current negedge and plays the slave cycle by cycle.
  task automatic run_vec(input vec_t v);
    int aw_t, w_t, ar_t, tb0, tbh, t_rsp;
    logic [5:0] exp_ch;
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    #1 check("gnt", 64'(req_gnt), 64'(1));
    exp_q.push_back({v.exp_err, v.exp_rdata});
    if (v.to) begin
      aw_t = TO; w_t = TO; ar_t = TO; tb0 = 1000; tbh = 0; t_rsp = TO + 1;
    end else begin
      aw_t  = 1 + v.a_dly;
      w_t   = 1 + v.w_dly;
      ar_t  = 1 + v.a_dly;
      tb0   = (v.we ? ((aw_t > w_t) ? aw_t : w_t) : ar_t) + 1;
      tbh   = tb0 + v.r_dly;
      t_rsp = tbh + 1;
    end
    for (int t = 1; t <= t_rsp; t++) begin
      @(negedge msoc_clk);
      if (t == 1) begin
        // competing request while busy must not be granted
        req_addr = 32'hFFFF_FFF0;
        req_we   = ~v.we;
        if (v.we) begin
          check("awaddr", 64'(ax.awaddr), 64'({v.addr[31:2], 2'b00}));
          check("wdata_strb_prot", 64'({ax.wdata, ax.wstrb, ax.awprot}), 64'({v.wdata, v.be, 3'b000}));
        end else begin
          check("araddr", 64'(ax.araddr), 64'({v.addr[31:2], 2'b00}));
        end
      end
      if (t < t_rsp) check("busy_gnt", 64'(req_gnt), 64'(0));
      exp_ch = {v.we && (t <= aw_t), v.we && (t <= w_t), !v.we && (t <= ar_t),
                v.we && (t >= tb0) && (t <= tbh), !v.we && (t >= tb0) && (t <= tbh), t == t_rsp};
      check("chan_aw_w_ar_b_r_rsp", 64'({ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, rsp_valid}),
            64'(exp_ch));
      ax.awready = v.we && !v.to && (t == aw_t);
      ax.wready  = v.we && !v.to && (t == w_t);
      ax.arready = !v.we && !v.to && (t == ar_t);
      ax.bvalid  = v.we && !v.to && (t == tbh);
      ax.rvalid  = !v.we && !v.to && (t == tbh);
      ax.bresp   = v.resp;
      ax.rresp   = v.resp;
      ax.rdata   = v.rdata;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0804, 32'hA5A5_1234, 4'hF, 0, 0, 0, AXI_RESP_OKAY,   32'h0,         1'b0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 5, 0, 0, AXI_RESP_OKAY,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 0, 3, 0, AXI_RESP_OKAY,   32'h0,         1'b0, 32'h0,         1'b0};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 1, AXI_RESP_SLVERR, 32'h1111_2222, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0807, 32'h0BAD_F00D, 4'h6, 2, 0, 1, AXI_RESP_DECERR, 32'h0,         1'b0, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 32'h0000_07FE, 32'h0,         4'h0, 0, 0, 2, 2'b01,           32'h55AA_00FF, 1'b0, 32'h55AA_00FF, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 0, 0, 0, AXI_RESP_OKAY,   32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_3000, 32'h7777_8888, 4'hC, 0, 0, 0, AXI_RESP_OKAY,   32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    slave_idle();
    repeat (3) @(negedge msoc_clk);
    check("reset_ctrl", 64'({ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, rsp_valid, rsp_err,
                            timeout_flag, m_axi_aresetn}), 64'(0));
    check("reset_data", 64'(ax.awaddr | ax.araddr | ax.wdata | rsp_rdata | 32'(ax.wstrb)), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rstn = 1'b1;
    #1 check("aresetn_hold", 64'(m_axi_aresetn), 64'(0));
    @(negedge msoc_clk);
    check("aresetn_rise", 64'(m_axi_aresetn), 64'(1));

    // each vector starts in the cycle its predecessor's rsp_valid pulses
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      seen_to = seen_to | vecs[i].to;
      check("timeout_flag", 64'(timeout_flag), 64'(seen_to));
    end

    // reset while waiting for B: everything drops, no response, late B ignored
    slave_idle();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'h1; req_be = 4'hF;
    #1 check("rst_gnt", 64'(req_gnt), 64'(1));
    @(negedge msoc_clk);
    req_valid = 1'b0;
    ax.awready = 1'b1; ax.wready = 1'b1;
    @(negedge msoc_clk);
    ax.awready = 1'b0; ax.wready = 1'b0;
    check("rst_in_wr_resp", 64'({ax.bready, dbg_state}), 64'({1'b1, ST_WR_RESP}));
    rstn = 1'b0;
    @(negedge msoc_clk);
    check("rst_drop", 64'({ax.awvalid, ax.wvalid, ax.arvalid, ax.bready, ax.rready, rsp_valid, timeout_flag,
                          m_axi_aresetn}), 64'(0));
    ax.bvalid = 1'b1;
    rstn = 1'b1;
    #1 check("rst_aresetn_low", 64'(m_axi_aresetn), 64'(0));
    @(negedge msoc_clk);
    check("rst_aresetn_high", 64'({m_axi_aresetn, ax.bready, rsp_valid}), 64'({1'b1, 1'b0, 1'b0}));
    repeat (3) @(negedge msoc_clk);
    ax.bvalid = 1'b0;
    check("idle_after", 64'(dbg_state), 64'(ST_IDLE));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
